// File: rtl/nexys4_io_pkg.sv
// Shared port map, per-bot snapshot record and interrupt FSM encoding for the
// Nexys4 multi-Rojobot PicoBlaze I/O block.
package nexys4_io_pkg;

  // Input/output port addresses seen by the PicoBlaze
  localparam logic [7:0] PA_BTNS     = 8'h00;
  localparam logic [7:0] PA_SW_LO    = 8'h01;
  localparam logic [7:0] PA_SW_HI    = 8'h11;
  localparam logic [7:0] PA_LED_LO   = 8'h02;
  localparam logic [7:0] PA_LED_HI   = 8'h12;
  localparam logic [7:0] PA_DIG0     = 8'h06;  // dig3..dig0 at 0x03..0x06
  localparam logic [7:0] PA_DIG4     = 8'h16;  // dig7..dig4 at 0x13..0x16
  localparam logic [7:0] PA_DP_LO    = 8'h07;
  localparam logic [7:0] PA_DP_HI    = 8'h17;
  localparam logic [7:0] PA_BOTSEL   = 8'h08;
  localparam logic [7:0] PA_MOTCTL   = 8'h09;
  localparam logic [7:0] PA_LOCX     = 8'h0A;
  localparam logic [7:0] PA_LOCY     = 8'h0B;
  localparam logic [7:0] PA_BOTINFO  = 8'h0C;
  localparam logic [7:0] PA_SENSORS  = 8'h0D;
  localparam logic [7:0] PA_LMDIST   = 8'h0E;
  localparam logic [7:0] PA_RMDIST   = 8'h0F;
  localparam logic [7:0] PA_INTMASK  = 8'h10;
  localparam logic [7:0] PA_INTSTAT  = 8'h18;

  // Interrupt handshake states
  typedef enum logic [1:0] {
    INT_IDLE    = 2'd0,
    INT_REQ     = 2'd1,
    INT_SERVICE = 2'd2
  } int_state_e;

  // One coherent sample of a Rojobot's status registers
  typedef struct packed {
    logic [7:0] locx;
    logic [7:0] locy;
    logic [7:0] botinfo;
    logic [7:0] sensors;
    logic [7:0] lmdist;
    logic [7:0] rmdist;
  } bot_snap_t;

  // The per-bot window 0x09..0x0F is mirrored at 0x19..0x1F; fold the alias
  // down so the decoder only has one set of addresses to match.
  function automatic logic [7:0] fold_alias(input logic [7:0] addr);
    if (addr[7:5] == 3'b000 && addr[3:0] >= 4'h9)
      return {4'h0, addr[3:0]};
    return addr;
  endfunction

endpackage

// File: rtl/nexys4_multibot_if_if.sv
// PicoBlaze I/O bus: port address, write/read strobes, read data and the
// interrupt request/acknowledge pair.
interface nexys4_multibot_if_if;
  logic [7:0] pb_port_id;
  logic [7:0] pb_out_port;
  logic       pb_write_strobe;
  logic       pb_read_strobe;
  logic       pb_interrupt_ack;
  logic [7:0] pb_in_port;
  logic       pb_interrupt;

  modport master (
    output pb_port_id, pb_out_port, pb_write_strobe, pb_read_strobe, pb_interrupt_ack,
    input  pb_in_port, pb_interrupt
  );

  modport slave (
    input  pb_port_id, pb_out_port, pb_write_strobe, pb_read_strobe, pb_interrupt_ack,
    output pb_in_port, pb_interrupt
  );
endinterface

// File: rtl/bot_snapshot_bank.sv
// Per-bot register bank: captures all six status bytes together on the bot's
// update pulse and holds the motor-control byte written by the CPU.
module bot_snapshot_bank
  import nexys4_io_pkg::*;
#(
  parameter logic [7:0] MOTCTL_RST = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       upd_i,
  input  bot_snap_t  snap_i,
  input  logic       motctl_we_i,
  input  logic [7:0] motctl_wdata_i,
  output bot_snap_t  snap_o,
  output logic [7:0] motctl_o
);

  bot_snap_t  snap_q;
  logic [7:0] motctl_q;

  // All six bytes load on the same edge so a read never mixes two updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   snap_q <= '0;
    else if (upd_i) snap_q <= snap_i;
  end

  // Motor-control byte written through the selected-bot window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         motctl_q <= MOTCTL_RST;
    else if (motctl_we_i) motctl_q <= motctl_wdata_i;
  end

  assign snap_o   = snap_q;
  assign motctl_o = motctl_q;

endmodule

// File: rtl/nexys4_multibot_if.sv
// PicoBlaze I/O interface for a Nexys4 board hosting several Rojobots:
// buttons/switches/LEDs/7-segment digits plus a bot-select window onto
// per-bot snapshots, motor control and a masked update interrupt.
module nexys4_multibot_if
  import nexys4_io_pkg::*;
#(
  parameter int         NUM_BOTS   = 2,
  parameter logic [7:0] MOTCTL_RST = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  nexys4_multibot_if_if.slave   pb,
  input  logic [8*NUM_BOTS-1:0] bot_locx,
  input  logic [8*NUM_BOTS-1:0] bot_locy,
  input  logic [8*NUM_BOTS-1:0] bot_botinfo,
  input  logic [8*NUM_BOTS-1:0] bot_sensors,
  input  logic [8*NUM_BOTS-1:0] bot_lmdist,
  input  logic [8*NUM_BOTS-1:0] bot_rmdist,
  input  logic [NUM_BOTS-1:0]   bot_upd_sysreg,
  input  logic [4:0]            db_btns,
  input  logic [15:0]           db_sw,
  output logic [8*NUM_BOTS-1:0] bot_motctl,
  output logic [4:0]            dig0,
  output logic [4:0]            dig1,
  output logic [4:0]            dig2,
  output logic [4:0]            dig3,
  output logic [4:0]            dig4,
  output logic [4:0]            dig5,
  output logic [4:0]            dig6,
  output logic [4:0]            dig7,
  output logic [7:0]            dp,
  output logic [15:0]           led
);

  localparam logic [7:0] NB8 = 8'(NUM_BOTS);

  logic [7:0] addr, wdata, port_f;
  logic       wr;
  assign addr   = pb.pb_port_id;
  assign wdata  = pb.pb_out_port;
  assign wr     = pb.pb_write_strobe;
  assign port_f = fold_alias(addr);

  // Read data is sampled from the address every cycle, strobe not needed
  logic unused_rd_strobe;
  assign unused_rd_strobe = pb.pb_read_strobe;

  logic [2:0]          botsel_q;
  logic [NUM_BOTS-1:0] mask_q, mask_d;
  logic [NUM_BOTS-1:0] pending_q, pending_d, clr_d;
  logic [15:0]         led_q;
  logic [4:0]          dig_q [8];
  logic [7:0]          dp_q;
  logic [7:0]          rd_d;
  int_state_e          state_q;
  logic                irq_q;
  logic                botsel_wr, intstat_wr, any_req_d;

  bot_snap_t  snap   [NUM_BOTS];
  logic [7:0] motctl [NUM_BOTS];
  bot_snap_t  sel_snap;
  logic [7:0] sel_motctl;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BOTS; gi++) begin : g_bot
      bot_snap_t snap_in;
      assign snap_in = {bot_locx[8*gi+:8], bot_locy[8*gi+:8], bot_botinfo[8*gi+:8],
                        bot_sensors[8*gi+:8], bot_lmdist[8*gi+:8], bot_rmdist[8*gi+:8]};

      bot_snapshot_bank #(.MOTCTL_RST(MOTCTL_RST)) u_bank (
        .clk            (clk),
        .reset_n        (reset),
        .upd_i          (bot_upd_sysreg[gi]),
        .snap_i         (snap_in),
        .motctl_we_i    (wr && port_f == PA_MOTCTL && botsel_q == 3'(gi)),
        .motctl_wdata_i (wdata),
        .snap_o         (snap[gi]),
        .motctl_o       (motctl[gi])
      );

      assign bot_motctl[8*gi+:8] = motctl[gi];
    end
  endgenerate

  assign botsel_wr  = wr && addr == PA_BOTSEL && wdata < NB8;
  assign intstat_wr = wr && addr == PA_INTSTAT;

  // Next mask/pending; a new update beats a simultaneous write-1-clear
  always_comb begin
    mask_d = mask_q;
    clr_d  = '0;
    if (wr && addr == PA_INTMASK) mask_d = wdata[NUM_BOTS-1:0];
    if (intstat_wr)               clr_d  = wdata[NUM_BOTS-1:0];
    pending_d = (pending_q & ~clr_d) | bot_upd_sysreg;
    any_req_d = |(pending_d & mask_d);
  end

  // Bot-select, interrupt mask and pending registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      botsel_q  <= '0;
      mask_q    <= '1;
      pending_q <= '0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      if (botsel_wr) botsel_q <= wdata[2:0];
    end
  end

  // Board outputs: LEDs, digit codes and decimal points
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
      dp_q  <= '0;
      for (int i = 0; i < 8; i++) dig_q[i] <= '0;
    end else if (wr) begin
      if (addr == PA_LED_LO) led_q[7:0]  <= wdata;
      if (addr == PA_LED_HI) led_q[15:8] <= wdata;
      if (addr == PA_DP_LO)  dp_q[3:0]   <= wdata[3:0];
      if (addr == PA_DP_HI)  dp_q[7:4]   <= wdata[3:0];
      for (int i = 0; i < 4; i++) begin
        if (addr == PA_DIG0 - 8'(i)) dig_q[i]     <= wdata[4:0];
        if (addr == PA_DIG4 - 8'(i)) dig_q[i + 4] <= wdata[4:0];
      end
    end
  end

  // Pick the selected bot's snapshot and motor-control byte
  always_comb begin
    sel_snap   = '0;
    sel_motctl = '0;
    for (int i = 0; i < NUM_BOTS; i++) begin
      if (botsel_q == 3'(i)) begin
        sel_snap   = snap[i];
        sel_motctl = motctl[i];
      end
    end
  end

  // Read-data decode; write-only and unmapped addresses read as zero
  always_comb begin
    rd_d = '0;
    case (port_f)
      PA_BTNS:    rd_d = {3'b000, db_btns};
      PA_SW_LO:   rd_d = db_sw[7:0];
      PA_SW_HI:   rd_d = db_sw[15:8];
      PA_BOTSEL:  rd_d = {5'b00000, botsel_q};
      PA_MOTCTL:  rd_d = sel_motctl;
      PA_LOCX:    rd_d = sel_snap.locx;
      PA_LOCY:    rd_d = sel_snap.locy;
      PA_BOTINFO: rd_d = sel_snap.botinfo;
      PA_SENSORS: rd_d = sel_snap.sensors;
      PA_LMDIST:  rd_d = sel_snap.lmdist;
      PA_RMDIST:  rd_d = sel_snap.rmdist;
      PA_INTMASK: rd_d[NUM_BOTS-1:0] = mask_q;
      PA_INTSTAT: rd_d[NUM_BOTS-1:0] = pending_q;
      default:    rd_d = '0;
    endcase
  end

  // Registered read port, one cycle behind the address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pb.pb_in_port <= '0;
    else        pb.pb_in_port <= rd_d;
  end

  // Interrupt FSM; looks at next-state pending so the request rises on the
  // cycle right after the update edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INT_IDLE;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        INT_IDLE: begin
          if (any_req_d) begin
            state_q <= INT_REQ;
            irq_q   <= 1'b1;
          end
        end
        INT_REQ: begin
          if (pb.pb_interrupt_ack) begin
            state_q <= INT_SERVICE;
            irq_q   <= 1'b0;
          end else if (!any_req_d) begin
            state_q <= INT_IDLE;
            irq_q   <= 1'b0;
          end
        end
        INT_SERVICE: begin
          if (intstat_wr) state_q <= INT_IDLE;
          irq_q <= 1'b0;
        end
        default: begin
          state_q <= INT_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pb.pb_interrupt = irq_q;
  assign led  = led_q;
  assign dp   = dp_q;
  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];
  assign dig4 = dig_q[4];
  assign dig5 = dig_q[5];
  assign dig6 = dig_q[6];
  assign dig7 = dig_q[7];

endmodule

// File: tb/tb_nexys4_multibot_if.sv
// Directed bench for nexys4_multibot_if: reads go through an expectation
// queue drained by a monitor; level checks are made directly.
module tb_nexys4_multibot_if;

  localparam int         NB   = 2;
  localparam logic [7:0] MRST = 8'h3C;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nexys4_multibot_if_if pb_if();

  logic [8*NB-1:0] bot_locx, bot_locy, bot_botinfo, bot_sensors, bot_lmdist, bot_rmdist;
  logic [NB-1:0]   upd;
  logic [4:0]      btns;
  logic [15:0]     sw;
  logic [8*NB-1:0] bot_motctl;
  logic [4:0]      dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
  logic [7:0]      dp;
  logic [15:0]     led;

  nexys4_multibot_if #(.NUM_BOTS(NB), .MOTCTL_RST(MRST)) dut (
    .clk(clk), .reset(reset), .pb(pb_if),
    .bot_locx(bot_locx), .bot_locy(bot_locy), .bot_botinfo(bot_botinfo),
    .bot_sensors(bot_sensors), .bot_lmdist(bot_lmdist), .bot_rmdist(bot_rmdist),
    .bot_upd_sysreg(upd), .db_btns(btns), .db_sw(sw), .bot_motctl(bot_motctl),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
    .dp(dp), .led(led)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endfunction

  // Monitor: a read issued on the previous edge presents data now
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= pb_if.pb_read_strobe;

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (rd_seen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", {24'h0, pb_if.pb_in_port}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("txn read  0x%02h -> 0x%02h (expect 0x%02h)", e.addr, pb_if.pb_in_port, e.exp);
        check($sformatf("read_0x%02h", e.addr), {24'h0, pb_if.pb_in_port}, {24'h0, e.exp});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] e);
    rd_exp_t item;
    item.addr = a;
    item.exp  = e;
    exp_q.push_back(item);
    pb_if.pb_port_id     = a;
    pb_if.pb_read_strobe = 1'b1;
    @(negedge clk);
    pb_if.pb_read_strobe = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    $display("txn write 0x%02h <- 0x%02h", a, d);
    pb_if.pb_port_id      = a;
    pb_if.pb_out_port     = d;
    pb_if.pb_write_strobe = 1'b1;
    @(negedge clk);
    pb_if.pb_write_strobe = 1'b0;
  endtask

  task automatic pulse(input logic [NB-1:0] m);
    $display("txn update pulse mask=%b", m);
    upd = m;
    @(negedge clk);
    upd = '0;
  endtask

  task automatic ack();
    $display("txn interrupt ack");
    pb_if.pb_interrupt_ack = 1'b1;
    @(negedge clk);
    pb_if.pb_interrupt_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pb_if.pb_port_id = '0; pb_if.pb_out_port = '0;
    pb_if.pb_write_strobe = 1'b0; pb_if.pb_read_strobe = 1'b0; pb_if.pb_interrupt_ack = 1'b0;
    bot_locx = 16'h2010; bot_locy = 16'h2111; bot_botinfo = 16'h2212;
    bot_sensors = 16'h2313; bot_lmdist = 16'h2414; bot_rmdist = 16'h2515;
    upd = '0; btns = '0; sw = '0;

    // Reset state
    repeat (3) tick();
    check("irq_in_reset", 32'(pb_if.pb_interrupt), 32'h0);
    check("motctl_in_reset", 32'(bot_motctl), 32'h3C3C);
    reset = 1'b1;
    tick();
    do_read(8'h10, 8'h03);
    do_read(8'h09, MRST);
    do_read(8'h08, 8'h00);
    do_read(8'h18, 8'h00);
    check("irq_after_reset", 32'(pb_if.pb_interrupt), 32'h0);

    // Buttons, switches, write-only and unmapped reads
    sw = 16'hA55A; btns = 5'h13;
    do_read(8'h00, 8'h13);
    do_read(8'h01, 8'h5A);
    do_read(8'h11, 8'hA5);
    do_read(8'h02, 8'h00);
    do_read(8'h20, 8'h00);

    // LEDs, digits, decimal points, unmapped write
    do_write(8'h02, 8'h12);
    do_write(8'h12, 8'h34);
    check("led", 32'(led), 32'h3412);
    do_write(8'h03, 8'hFF);
    check("dig3", 32'(dig3), 32'h1F);
    do_write(8'h16, 8'h07);
    check("dig4", 32'(dig4), 32'h07);
    do_write(8'h06, 8'h0A);
    check("dig0", 32'(dig0), 32'h0A);
    do_write(8'h07, 8'hF5);
    do_write(8'h17, 8'h0A);
    check("dp", 32'(dp), 32'hA5);
    do_write(8'h20, 8'hFF);
    check("led_after_unmapped_write", 32'(led), 32'h3412);

    // Interrupt handshake
    pulse(2'b01);
    check("irq_after_upd0", 32'(pb_if.pb_interrupt), 32'h1);
    ack();
    check("irq_after_ack", 32'(pb_if.pb_interrupt), 32'h0);
    pulse(2'b10);
    check("irq_upd_in_service", 32'(pb_if.pb_interrupt), 32'h0);
    tick();
    check("irq_still_in_service", 32'(pb_if.pb_interrupt), 32'h0);
    do_read(8'h18, 8'h03);
    do_write(8'h18, 8'h01);
    check("irq_service_to_idle", 32'(pb_if.pb_interrupt), 32'h0);
    tick();
    check("irq_reasserted", 32'(pb_if.pb_interrupt), 32'h1);
    do_read(8'h18, 8'h02);
    ack();
    do_write(8'h18, 8'h02);
    tick();
    check("irq_all_cleared", 32'(pb_if.pb_interrupt), 32'h0);

    // Masking the only pending bit while requesting
    pulse(2'b10);
    check("irq_upd1", 32'(pb_if.pb_interrupt), 32'h1);
    do_write(8'h10, 8'h01);
    check("irq_masked_off", 32'(pb_if.pb_interrupt), 32'h0);
    do_read(8'h10, 8'h01);
    do_read(8'h18, 8'h02);
    do_write(8'h18, 8'h02);
    do_write(8'h10, 8'hFF);
    do_read(8'h10, 8'h03);
    check("irq_idle_after_unmask", 32'(pb_if.pb_interrupt), 32'h0);

    // Update and write-1-clear on the same edge: the update wins
    pb_if.pb_port_id = 8'h18; pb_if.pb_out_port = 8'h01; pb_if.pb_write_strobe = 1'b1;
    upd = 2'b01;
    $display("txn write 0x18 <- 0x01 with update pulse mask=01");
    tick();
    pb_if.pb_write_strobe = 1'b0; upd = '0;
    check("irq_after_collision", 32'(pb_if.pb_interrupt), 32'h1);
    do_read(8'h18, 8'h01);
    ack();
    do_write(8'h18, 8'h01);
    do_read(8'h18, 8'h00);
    check("irq_after_collision_clear", 32'(pb_if.pb_interrupt), 32'h0);

    // Snapshot coherence for bot 1 and bot 0
    bot_locx = 16'h4099; bot_locy = 16'h4199; bot_botinfo = 16'h4299;
    bot_sensors = 16'h4399; bot_lmdist = 16'h4499; bot_rmdist = 16'h4599;
    pulse(2'b10);
    bot_locx = 16'h5598; bot_locy = 16'h5A5A; bot_botinfo = 16'h5A5A;
    bot_sensors = 16'h5A5A; bot_lmdist = 16'h5A5A; bot_rmdist = 16'h5A5A;
    do_write(8'h08, 8'h01);
    do_read(8'h0A, 8'h40);
    do_read(8'h1B, 8'h41);
    do_read(8'h0C, 8'h42);
    do_read(8'h0D, 8'h43);
    do_read(8'h0E, 8'h44);
    do_read(8'h1F, 8'h45);
    do_write(8'h08, 8'h00);
    do_read(8'h1A, 8'h10);
    do_read(8'h0F, 8'h15);

    // Bot-select bounds and per-bot motor control
    do_write(8'h08, 8'h01);
    do_write(8'h08, 8'h05);
    do_read(8'h08, 8'h01);
    do_write(8'h19, 8'hA5);
    check("motctl_bot1_write", 32'(bot_motctl), 32'hA53C);
    do_read(8'h09, 8'hA5);
    do_write(8'h08, 8'h00);
    do_read(8'h09, MRST);
    do_write(8'h09, 8'h77);
    check("motctl_bot0_write", 32'(bot_motctl), 32'hA577);

    // Asynchronous reset while requesting
    check("irq_before_async_reset", 32'(pb_if.pb_interrupt), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("irq_async_reset", 32'(pb_if.pb_interrupt), 32'h0);
    check("motctl_async_reset", 32'(bot_motctl), 32'h3C3C);
    check("led_async_reset", 32'(led), 32'h0);
    check("dp_async_reset", 32'(dp), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    do_read(8'h18, 8'h00);
    do_read(8'h10, 8'h03);
    do_read(8'h08, 8'h00);
    check("irq_after_release", 32'(pb_if.pb_interrupt), 32'h0);

    // Drain outstanding read expectations
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0)
      check("reads_outstanding", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nexys4_multibot_if.md
NEXYS4_MULTIBOT_IF -- requirements
Module: nexys4_multibot_if

Interface
REQ-001 SHALL have parameter NUM_BOTS, default 2, legal 1..8: number of Rojobot channels.
REQ-002 SHALL have parameter MOTCTL_RST, default 8'h00: reset value of every motor-control byte.
REQ-003 SHALL have ports clk  in  1  system clock; reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports pb_port_id  in  8  port address; pb_out_port  in  8  write data; pb_write_strobe  in  1  write; pb_read_strobe  in  1  read; pb_interrupt_ack  in  1  CPU acknowledge.
REQ-005 SHALL have ports bot_locx, bot_locy, bot_botinfo, bot_sensors, bot_lmdist, bot_rmdist  in  8*NUM_BOTS  packed per-bot registers, bot i at [8i+7:8i].
REQ-006 SHALL have ports bot_upd_sysreg  in  NUM_BOTS  per-bot one-cycle update pulse; db_btns  in  5  debounced buttons; db_sw  in  16  debounced switches.
REQ-007 SHALL have ports bot_motctl  out  8*NUM_BOTS  per-bot motor control; pb_in_port  out  8  read data; pb_interrupt  out  1  CPU interrupt.
REQ-008 SHALL have ports dig0..dig7  out  5 each  digit codes; dp  out  8  decimal points; led  out  16  LEDs.

Function
REQ-009 Port map SHALL be: 0x00 btns(R); 0x01 sw[7:0](R); 0x11 sw[15:8](R); 0x02/0x12 led low/high(W); 0x03-0x06 dig3..dig0(W); 0x13-0x16 dig7..dig4(W); 0x07/0x17 dp[3:0]/dp[7:4](W).
REQ-010 Port 0x08 BOTSEL SHALL be R/W; writes with value >= NUM_BOTS ignored; read returns selected index, upper bits zero.
REQ-011 Port 0x09 (alias 0x19) SHALL write bot_motctl of selected bot and read back that bot's motctl register.
REQ-012 Ports 0x0A-0x0F (aliases 0x1A-0x1F) SHALL read locx, locy, botinfo, sensors, lmdist, rmdist snapshot of selected bot.
REQ-013 Snapshot of bot i SHALL load all six inputs on the clock edge where bot_upd_sysreg[i]=1; reads never see a mix of two updates.
REQ-014 Port 0x18 INTSTAT SHALL read pending[NUM_BOTS-1:0] (upper bits zero); write clears each pending bit whose data bit is 1.
REQ-015 Port 0x10 INTMASK SHALL be R/W, bit i=1 enables bot i; reset value all ones for implemented bits.
REQ-016 pending[i] SHALL set on bot_upd_sysreg[i]=1; simultaneous set and write-1-clear: set wins.
REQ-017 pb_in_port SHALL be registered every cycle from pb_port_id (one-cycle latency, independent of pb_read_strobe); unmapped or write-only addresses return 8'h00.
REQ-018 Writes SHALL take effect on the edge where pb_write_strobe=1; unmapped write addresses have no effect; digit writes take pb_out_port[4:0], dp writes take [3:0].
REQ-019 Interrupt FSM SHALL have states IDLE, REQ, SERVICE: IDLE->REQ when (pending & mask)!=0; REQ->SERVICE on pb_interrupt_ack; SERVICE->IDLE on any write to INTSTAT.
REQ-020 pb_interrupt SHALL be 1 exactly in REQ, registered; asserted first cycle after the qualifying pending edge.
REQ-021 Updates arriving during SERVICE SHALL set pending but not re-raise pb_interrupt until SERVICE->IDLE; if unmasked pending remain then, IDLE->REQ next cycle.
REQ-022 Masking all pending bits while in REQ SHALL return FSM to IDLE and drop pb_interrupt next cycle.

Reset
REQ-023 On reset low, SHALL asynchronously clear: pb_in_port, pb_interrupt, dig0..dig7, dp, led, BOTSEL, pending, snapshots to zero; bot_motctl bytes to MOTCTL_RST; INTMASK to ones; FSM to IDLE.
REQ-024 Reset mid-transaction SHALL discard the in-flight write and any pending interrupt; release is synchronous-safe (no write on the release edge unless strobe present).

Structure
REQ-025 Port-address constants and FSM state encodings SHALL live in shared package nexys4_io_pkg.
REQ-026 Per-bot snapshot and motctl register SHALL be sub-module bot_snapshot_bank, instantiated NUM_BOTS times by generate.

Verification
REQ-027 Reset: after reset release, read 0x10 -> 8'h03 (NUM_BOTS=2), read 0x09 -> MOTCTL_RST, pb_interrupt=0.
REQ-028 Snapshot: pulse upd[1] with locx=0x40, then change locx to 0x55 without pulse; BOTSEL=1, read 0x0A -> 0x40.
REQ-029 Interrupt: upd[0] pulse -> pb_interrupt=1 next cycle; ack -> 0; upd[1] during SERVICE -> stays 0; write 0x01 to 0x18 -> re-asserts; INTSTAT reads 0x02.
REQ-030 Collision: upd[0] on same edge as write 0x01 to 0x18 -> INTSTAT bit0 remains 1.
REQ-031 Select bounds: write 0x05 to 0x08 with NUM_BOTS=2 -> read 0x08 returns previous value; write 0xA5 to 0x19 updates only bot_motctl of selected bot.
REQ-032 Async reset asserted mid-REQ -> pb_interrupt low same cycle without clock, pending read 0x00 after release.
